// File: rtl/phase_unwrap_averager.sv
// Unwraps a wrapped CORDIC phase stream into a wide accumulator, block-averages
// 2^LOG2_AVG samples and emits average phase plus block-to-block difference.
module phase_unwrap_averager #(
    parameter int PHASE_BITS   = 16,
    parameter int MAG_BITS     = 14,
    parameter int UNWRAP_WIDTH = 48,
    parameter int LOG2_AVG     = 4,
    parameter int MAG_THRESH   = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PHASE_BITS-1:0]   s_phase_tdata,
    input  logic [MAG_BITS-1:0]     s_mag_tdata,
    input  logic                    s_tvalid,
    output logic [UNWRAP_WIDTH-1:0] m_avg_tdata,
    output logic [UNWRAP_WIDTH-1:0] m_freq_tdata,
    output logic                    m_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    locked,
    output logic [15:0]             overflow_cnt
);

    localparam int SUM_W = UNWRAP_WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0]    BLOCK_LEN    = CNT_W'(1 << LOG2_AVG);
    localparam logic [MAG_BITS-1:0] MAG_THRESH_V = MAG_BITS'(MAG_THRESH);

    typedef enum logic {SEED = 1'b0, RUN = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PHASE_BITS-1:0]   r_prev_phase;
    logic [UNWRAP_WIDTH-1:0] r_unwrap;
    logic [SUM_W-1:0]        r_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_unlock;
    logic                    r_first_block;
    logic [UNWRAP_WIDTH-1:0] r_prev_avg;
    logic [UNWRAP_WIDTH-1:0] r_m_avg;
    logic [UNWRAP_WIDTH-1:0] r_m_freq;
    logic                    r_m_tuser;
    logic                    r_m_tvalid;
    logic                    r_locked;
    logic [15:0]             r_overflow_cnt;

    logic                    w_sample;
    logic [PHASE_BITS-1:0]   w_delta;
    logic [UNWRAP_WIDTH-1:0] w_unwrap_next;
    logic [SUM_W-1:0]        w_sum_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_mag_low;
    logic                    w_unlock_next;
    logic                    w_block_done;
    logic [UNWRAP_WIDTH-1:0] w_avg;
    logic [UNWRAP_WIDTH-1:0] w_freq;
    logic                    w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEED:    if (w_sample) w_state_next = RUN;
            RUN:     if (!en)      w_state_next = SEED;
            default: w_state_next = SEED;
        endcase
    end

    // The seeding sample contributes a zero delta so the accumulator carries on
    // from wherever it was rather than jumping to the new wrapped phase.
    always_comb begin
        w_sample      = en && s_tvalid;
        w_delta       = (r_state == RUN) ? (s_phase_tdata - r_prev_phase) : '0;
        w_unwrap_next = r_unwrap + {{(UNWRAP_WIDTH-PHASE_BITS){w_delta[PHASE_BITS-1]}}, w_delta};
        w_sum_next    = r_sum + {{LOG2_AVG{w_unwrap_next[UNWRAP_WIDTH-1]}}, w_unwrap_next};
        w_cnt_next    = r_cnt + 1'b1;
        w_mag_low     = (s_mag_tdata < MAG_THRESH_V);
        w_unlock_next = r_unlock | w_mag_low;
        w_block_done  = w_sample && (w_cnt_next == BLOCK_LEN);
        w_avg         = w_sum_next[SUM_W-1:LOG2_AVG];
        w_freq        = r_first_block ? '0 : (w_avg - r_prev_avg);
        w_load        = w_block_done && (!r_m_tvalid || m_tready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_phase   <= '0;
            r_unwrap       <= '0;
            r_sum          <= '0;
            r_cnt          <= '0;
            r_unlock       <= 1'b0;
            r_first_block  <= 1'b1;
            r_prev_avg     <= '0;
            r_m_avg        <= '0;
            r_m_freq       <= '0;
            r_m_tuser      <= 1'b0;
            r_m_tvalid     <= 1'b0;
            r_locked       <= 1'b0;
            r_overflow_cnt <= '0;
        end else begin
            if (w_sample) begin
                r_prev_phase <= s_phase_tdata;
                r_unwrap     <= w_unwrap_next;
                r_locked     <= !w_mag_low;
                if (w_block_done) begin
                    r_sum         <= '0;
                    r_cnt         <= '0;
                    r_unlock      <= 1'b0;
                    r_prev_avg    <= w_avg;
                    r_first_block <= 1'b0;
                end else begin
                    r_sum    <= w_sum_next;
                    r_cnt    <= w_cnt_next;
                    r_unlock <= w_unlock_next;
                end
            end else if (!en) begin
                r_sum         <= '0;
                r_cnt         <= '0;
                r_unlock      <= 1'b0;
                r_first_block <= 1'b1;
            end

            if (w_load) begin
                r_m_avg    <= w_avg;
                r_m_freq   <= w_freq;
                r_m_tuser  <= w_unlock_next;
                r_m_tvalid <= 1'b1;
            end else if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            // A finished block that cannot be loaded is lost; prev_avg still advanced above.
            if (w_block_done && !w_load && (r_overflow_cnt != 16'hFFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 16'd1;
            end
        end
    end

    assign m_avg_tdata  = r_m_avg;
    assign m_freq_tdata = r_m_freq;
    assign m_tuser      = r_m_tuser;
    assign m_tvalid     = r_m_tvalid;
    assign locked       = r_locked;
    assign overflow_cnt = r_overflow_cnt;

endmodule

// File: tb/tb_phase_unwrap_averager.sv
// Randomized bench for phase_unwrap_averager against a sample-list reference model.
module tb_phase_unwrap_averager;

    localparam int N      = 16;
    localparam int THRESH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] s_phase_tdata;
    logic [13:0] s_mag_tdata;
    logic        s_tvalid;
    logic [47:0] m_avg_tdata;
    logic [47:0] m_freq_tdata;
    logic        m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        locked;
    logic [15:0] overflow_cnt;

    int checks   = 0;
    int failures = 0;
    int beats    = 0;

    phase_unwrap_averager dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_phase_tdata (s_phase_tdata),
        .s_mag_tdata   (s_mag_tdata),
        .s_tvalid      (s_tvalid),
        .m_avg_tdata   (m_avg_tdata),
        .m_freq_tdata  (m_freq_tdata),
        .m_tuser       (m_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .locked        (locked),
        .overflow_cnt  (overflow_cnt)
    );

    always #4 clk = ~clk;

    // Reference model state
    bit          md_seeded;
    int          md_prev;
    logic [47:0] md_unw;
    longint      md_blk[$];
    bit          md_unlock;
    bit          md_first;
    logic [47:0] md_prev_avg;
    bit          md_mv;
    logic [47:0] md_avg;
    logic [47:0] md_freq;
    bit          md_user;
    int          md_ovf;
    bit          md_locked;

    int cur_ph = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_seeded   = 0;
        md_prev     = 0;
        md_unw      = '0;
        md_blk.delete();
        md_unlock   = 0;
        md_first    = 1;
        md_prev_avg = '0;
        md_mv       = 0;
        md_avg      = '0;
        md_freq     = '0;
        md_user     = 0;
        md_ovf      = 0;
        md_locked   = 0;
    endtask

    // Plain-arithmetic view: wrapped delta folded into [-32768, 32767], average = floor(sum/N).
    task automatic model_tick(input bit e, input bit v, input int ph, input int mg, input bit rdy);
        bit          done;
        int          d;
        longint      s;
        longint      avg_l;
        logic [47:0] avg48;
        logic [47:0] fr;
        bit          usr;
        done  = 0;
        avg48 = '0;
        fr    = '0;
        usr   = 0;
        if (e && v) begin
            if (!md_seeded) begin
                d = 0;
                md_seeded = 1;
            end else begin
                d = (ph - md_prev) & 32'hFFFF;
                if (d >= 32768) d = d - 65536;
            end
            md_unw    = md_unw + 48'(longint'(d));
            md_prev   = ph;
            md_locked = (mg >= THRESH);
            md_unlock = md_unlock || (mg < THRESH);
            md_blk.push_back(longint'($signed(md_unw)));
            if (md_blk.size() == N) begin
                s = 0;
                foreach (md_blk[i]) s += md_blk[i];
                avg_l = s >>> 4;
                avg48 = avg_l[47:0];
                fr    = md_first ? 48'd0 : (avg48 - md_prev_avg);
                usr   = md_unlock;
                md_prev_avg = avg48;
                md_first    = 0;
                md_blk.delete();
                md_unlock   = 0;
                done        = 1;
            end
        end else if (!e) begin
            md_seeded = 0;
            md_blk.delete();
            md_unlock = 0;
            md_first  = 1;
        end
        if (done && (!md_mv || rdy)) begin
            md_mv   = 1;
            md_avg  = avg48;
            md_freq = fr;
            md_user = usr;
        end else begin
            if (done && md_ovf < 65535) md_ovf++;
            if (!done && md_mv && rdy) md_mv = 0;
        end
    endtask

    task automatic compare_outputs();
        check("m_tvalid", 64'(m_tvalid), 64'(md_mv));
        if (md_mv) begin
            check("m_avg_tdata", 64'(m_avg_tdata), 64'(md_avg));
            check("m_freq_tdata", 64'(m_freq_tdata), 64'(md_freq));
            check("m_tuser", 64'(m_tuser), 64'(md_user));
        end
        check("overflow_cnt", 64'(overflow_cnt), 64'(md_ovf));
        check("locked", 64'(locked), 64'(md_locked));
    endtask

    task automatic step(input bit e, input bit v, input int ph, input int mg, input bit rdy);
        bool_accept_log(rdy);
        en            = e;
        s_tvalid      = v;
        s_phase_tdata = 16'(ph);
        s_mag_tdata   = 14'(mg);
        m_tready      = rdy;
        model_tick(e, v, ph & 32'hFFFF, mg, rdy);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic bool_accept_log(input bit rdy);
        if (m_tvalid && rdy) begin
            beats++;
            $display("beat %0d avg=%0d freq=%0d tuser=%0b ovf=%0d", beats,
                     $signed(m_avg_tdata), $signed(m_freq_tdata), m_tuser, overflow_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check("rst_m_avg_zero", 64'(m_avg_tdata), 64'd0);
        check("rst_m_freq_zero", 64'(m_freq_tdata), 64'd0);
        check("rst_m_tuser_zero", 64'(m_tuser), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_step(input int full_pct, input int en_low_pct, input int rdy_pct);
        int r;
        int mg;
        r = int'($urandom_range(0, 99));
        if (r < full_pct) cur_ph = int'($urandom_range(0, 65535));
        else              cur_ph = (cur_ph + int'($urandom_range(0, 600)) - 300) & 32'hFFFF;
        mg = ($urandom_range(0, 99) < 5) ? int'($urandom_range(0, THRESH - 1))
                                         : int'($urandom_range(THRESH, 16383));
        step(($urandom_range(0, 99) >= en_low_pct), ($urandom_range(0, 99) < 80),
             cur_ph, mg, ($urandom_range(0, 99) < rdy_pct));
    endtask

    initial begin
        rst           = 1'b0;
        en            = 1'b0;
        s_tvalid      = 1'b0;
        s_phase_tdata = '0;
        s_mag_tdata   = '0;
        m_tready      = 1'b0;
        model_reset();
        #2;
        do_reset();

        for (int i = 0; i < 600; i++) rand_step(2, 2, 70);

        // Wrap crossings in both directions with steady ramp around them
        for (int i = 0; i < 40; i++) begin
            cur_ph = (i % 2 == 0) ? 32760 : 32770;
            step(1, 1, cur_ph, 1000, 1);
        end
        for (int i = 0; i < 40; i++) begin
            cur_ph = (cur_ph - 7) & 32'hFFFF;
            step(1, 1, cur_ph, (i == 20) ? 100 : 1000, 1);
        end

        // Backpressure across several block completions, then release
        for (int i = 0; i < 3 * N + 4; i++) begin
            cur_ph = (cur_ph + 100) & 32'hFFFF;
            step(1, 1, cur_ph, 1000, 0);
        end
        for (int i = 0; i < 4; i++) step(1, 0, cur_ph, 1000, 1);

        // Enable drop mid-block, then resume
        for (int i = 0; i < 5; i++) begin
            cur_ph = (cur_ph + 100) & 32'hFFFF;
            step(1, 1, cur_ph, 1000, 1);
        end
        for (int i = 0; i < 6; i++) step(0, 1, 12345, 1000, 1);
        for (int i = 0; i < 2 * N + 3; i++) begin
            cur_ph = (cur_ph + 100) & 32'hFFFF;
            step(1, 1, cur_ph, 1000, 1);
        end

        // Reset while a beat is pending and a block is partly filled
        for (int i = 0; i < 2 * N + 5; i++) begin
            cur_ph = (cur_ph + 50) & 32'hFFFF;
            step(1, 1, cur_ph, 1000, 0);
        end
        do_reset();
        for (int i = 0; i < 2 * N + 5; i++) begin
            cur_ph = (cur_ph + 50) & 32'hFFFF;
            step(1, 1, cur_ph, 1000, 1);
        end

        for (int i = 0; i < 1500; i++) rand_step(10, 1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
